hcsr04_echo_responder: RTL

// - Sensor-side responder of the HC-SR04 trigger/echo ranging protocol, for hardware-in-the-loop and bench use.
// - Accepts the rover's trigger pulse, waits a fixed burst delay, then drives an echo pulse whose width encodes a programmed distance.
// - Lets the proximity/crash logic be exercised on the Basys3 (100 MHz) without a physical sensor.

---
 rtl/hcsr04_echo_responder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/hcsr04_echo_responder.sv
// HC-SR04 sensor emulator: qualifies a trigger pulse, waits a burst delay, then drives an echo whose width encodes distance_cm.
// Echo rises BURST_CYCLES after the start edge. There is no backpressure: trigger activity while busy is ignored.
module hcsr04_echo_responder #(
  parameter int unsigned MIN_TRIG_CYCLES = 1000,
  parameter bit          START_ON_FALL   = 1'b1,
  parameter int unsigned BURST_CYCLES    = 20000,
  parameter int unsigned CYCLES_PER_CM   = 5882,
  parameter int unsigned MAX_RANGE_CM    = 400,
  parameter int unsigned TIMEOUT_CYCLES  = 3800000,
  parameter int unsigned HOLDOFF_CYCLES  = 6000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trigger,
  input  logic [8:0]  distance_cm,
  input  logic        object_present,
  output logic        echo,
  output logic        busy,
  output logic        trig_short,
  output logic [15:0] meas_count
);

  localparam logic [31:0] MIN_C   = 32'(MIN_TRIG_CYCLES);
  localparam logic [31:0] BURST_C = 32'(BURST_CYCLES);
  localparam logic [31:0] CPC_C   = 32'(CYCLES_PER_CM);
  localparam logic [31:0] MAX_C   = 32'(MAX_RANGE_CM);
  localparam logic [31:0] TO_C    = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] HOLD_C  = 32'(HOLDOFF_CYCLES);

  typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;

  state_t      state, state_nxt;
  logic [31:0] trig_cnt, trig_cnt_nxt;
  logic [31:0] phase_cnt, phase_cnt_nxt;
  logic [31:0] hold_cnt, hold_cnt_nxt;
  logic [31:0] echo_len, echo_len_nxt;
  logic [31:0] start_len;
  logic        echo_nxt, busy_nxt, trig_short_nxt;
  logic [15:0] meas_count_nxt;
  logic        trig_q, trig_fall, start;
  logic [1:0]  rst_sync;
  logic        rst_n;

  // Assert asynchronously, release two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign trig_fall = trig_q & ~trigger;

  always_comb begin
    if (!object_present || distance_cm == 9'd0 || {23'd0, distance_cm} > MAX_C)
      start_len = TO_C;
    else
      start_len = {23'd0, distance_cm} * CPC_C;
  end

  always_comb begin
    state_nxt      = state;
    trig_cnt_nxt   = trig_cnt;
    phase_cnt_nxt  = phase_cnt;
    hold_cnt_nxt   = hold_cnt;
    echo_len_nxt   = echo_len;
    echo_nxt       = echo;
    busy_nxt       = busy;
    trig_short_nxt = 1'b0;
    meas_count_nxt = meas_count;
    start          = 1'b0;
    case (state)
      IDLE: begin
        // Level-sensitive, so a trigger still high after holdoff re-arms at once.
        if (trigger) begin
          state_nxt    = TRIG_HI;
          trig_cnt_nxt = 32'd1;
        end
      end
      TRIG_HI: begin
        if (trig_fall) begin
          if (START_ON_FALL && trig_cnt >= MIN_C) begin
            start = 1'b1;
          end else begin
            trig_short_nxt = 1'b1;
            trig_cnt_nxt   = 32'd0;
            state_nxt      = IDLE;
          end
        end else if (!START_ON_FALL && trig_cnt + 32'd1 >= MIN_C) begin
          start = 1'b1;
        end else if (trig_cnt < MIN_C) begin
          trig_cnt_nxt = trig_cnt + 32'd1;
        end
      end
      BURST: begin
        hold_cnt_nxt = hold_cnt + 32'd1;
        if (phase_cnt + 32'd1 >= BURST_C) begin
          echo_nxt      = 1'b1;
          phase_cnt_nxt = 32'd0;
          state_nxt     = ECHO;
        end else begin
          phase_cnt_nxt = phase_cnt + 32'd1;
        end
      end
      ECHO: begin
        hold_cnt_nxt = hold_cnt + 32'd1;
        if (phase_cnt + 32'd1 >= echo_len) begin
          echo_nxt       = 1'b0;
          meas_count_nxt = meas_count + 16'd1;
          phase_cnt_nxt  = 32'd0;
          state_nxt      = HOLDOFF;
        end else begin
          phase_cnt_nxt = phase_cnt + 32'd1;
        end
      end
      HOLDOFF: begin
        hold_cnt_nxt = hold_cnt + 32'd1;
        // hold_cnt lags the cycles-since-start by one, hence the +1.
        if (hold_cnt + 32'd1 >= HOLD_C) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (start) begin
      state_nxt     = BURST;
      trig_cnt_nxt  = 32'd0;
      phase_cnt_nxt = 32'd0;
      hold_cnt_nxt  = 32'd0;
      echo_len_nxt  = start_len;
      busy_nxt      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      trig_q     <= 1'b0;
      trig_cnt   <= 32'd0;
      phase_cnt  <= 32'd0;
      hold_cnt   <= 32'd0;
      echo_len   <= 32'd0;
      echo       <= 1'b0;
      busy       <= 1'b0;
      trig_short <= 1'b0;
      meas_count <= 16'd0;
    end else begin
      state      <= state_nxt;
      trig_q     <= trigger;
      trig_cnt   <= trig_cnt_nxt;
      phase_cnt  <= phase_cnt_nxt;
      hold_cnt   <= hold_cnt_nxt;
      echo_len   <= echo_len_nxt;
      echo       <= echo_nxt;
      busy       <= busy_nxt;
      trig_short <= trig_short_nxt;
      meas_count <= meas_count_nxt;
    end
  end

endmodule
